// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler for an 8:1 mux. Holds each grant for at most MAX_HOLD
// cycles, hands off to the next requester without idle cycles, and pulses done.
module mux8_rr_scheduler #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic [7:0] data_in,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic [7:0] grant,
    output logic       busy,
    output logic       data_out,
    output logic       done
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  ptr_r;
    logic [2:0]  ptr_s;
    logic [2:0]  idx_r;
    logic [2:0]  idx_s;
    logic [3:0]  hold_cnt_r;
    logic [3:0]  hold_cnt_s;
    logic        release_s;
    logic        done_s;
    logic        done_r;
    logic [7:0]  grant_s;
    logic [7:0]  grant_r;
    logic        busy_s;
    logic        busy_r;
    logic [2:0]  sel_s;
    logic [2:0]  sel_r;
    logic        data_out_s;

    // First set request bit at or above start, wrapping 7 -> 0.
    function automatic logic [2:0] rr_pick(input logic [7:0] req_v, input logic [2:0] start);
        logic [2:0] cand;
        logic [2:0] pick;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cand = start + 3'(i);
            if (!found && req_v[cand]) begin
                pick  = cand;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // State register and arbitration bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            ptr_r      <= 3'd0;
            idx_r      <= 3'd0;
            hold_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            idx_r      <= idx_s;
            hold_cnt_r <= hold_cnt_s;
        end
    end

    // Next-state logic: arbitration, hold counting and release handling.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        idx_s      = idx_r;
        hold_cnt_s = hold_cnt_r;
        release_s  = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req != 8'h00) begin
                    state_s    = GRANT;
                    idx_s      = rr_pick(req, ptr_r);
                    hold_cnt_s = 4'd0;
                end else begin
                    state_s    = IDLE;
                end
            end
            GRANT: begin
                release_s = (req[idx_r] == 1'b0) || (hold_cnt_r == HOLD_LAST);
                if (release_s) begin
                    done_s     = 1'b1;
                    ptr_s      = idx_r + 3'd1;
                    hold_cnt_s = 4'd0;
                    // Re-arbitrate in the same edge; a lone holder wins again via wrap-around.
                    if (req != 8'h00) begin
                        state_s = GRANT;
                        idx_s   = rr_pick(req, idx_r + 3'd1);
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    hold_cnt_s = hold_cnt_r + 4'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state; select holds its last value while idle.
    always_comb begin
        grant_s = 8'h00;
        busy_s  = 1'b0;
        sel_s   = sel_r;
        if (state_s == GRANT) begin
            grant_s = 8'h01 << idx_s;
            busy_s  = 1'b1;
            sel_s   = idx_s;
        end else begin
            grant_s = 8'h00;
            busy_s  = 1'b0;
            sel_s   = sel_r;
        end
    end

    // Output registers; reset drops done so an interrupted grant never signals completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_r <= 8'h00;
            busy_r  <= 1'b0;
            sel_r   <= 3'd0;
            done_r  <= 1'b0;
        end else begin
            grant_r <= grant_s;
            busy_r  <= busy_s;
            sel_r   <= sel_s;
            done_r  <= done_s;
        end
    end

    // Mux datapath: live data while busy, forced low while idle.
    always_comb begin
        data_out_s = 1'b0;
        if (busy_r) begin
            data_out_s = data_in[sel_r];
        end else begin
            data_out_s = 1'b0;
        end
    end

    assign grant    = grant_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign s0       = sel_r[0];
    assign s1       = sel_r[1];
    assign s2       = sel_r[2];
    assign data_out = data_out_s;

endmodule
